// File: rtl/dup_txfifo.sv
// rtl/dup_txfifo.sv - DUP11 TXDBUF backed by a DEPTH-entry {ABRT,EOM,SOM,DATA} transmit FIFO
// Optional sticky overflow flag: DUPTXFIFO_OVF_EN
module dup_txfifo #(
    parameter int DEPTH  = 4,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dupINIT,
    input  logic              devLOBYTE,
    input  logic              devHIBYTE,
    input  logic              txdbufWRITE,
    input  logic [35:0]       dupDATAI,
    input  logic              dupRXCRC,
    input  logic              dupTXCRC,
    input  logic              dupMNTT,
    output logic [15:0]       regTXDBUF,
    output logic              txVALID,
    input  logic              txREADY,
    output logic [DWIDTH-1:0] txDAT,
    output logic              txSOM,
    output logic              txEOM,
    output logic              txABRT,
    output logic              txEMPTY,
    output logic              txFULL,
    output logic [$clog2(DEPTH):0] txLEVEL,
    output logic              txOVF,
    input  logic              ovfCLR
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int FW = DWIDTH + 3;

    logic [FW-1:0]     mem [DEPTH];
    logic [PW-1:0]     wrPtr, rdPtr, rdPtrNext;
    logic [LW-1:0]     levelNext;
    logic [2:0]        staged;      // {ABRT_s, EOM_s, SOM_s}
    logic [2:0]        primed;
    logic [DWIDTH-1:0] datLast;
    logic [FW-1:0]     pushData, headNext;
    logic              clear, hiWr, loWr, pop, pushOk, dropped;

    assign clear    = rst | dupINIT;
    assign hiWr     = txdbufWRITE & devHIBYTE;
    assign loWr     = txdbufWRITE & devLOBYTE;
    assign primed   = hiWr ? dupDATAI[10:8] : staged;
    assign pushData = {primed, dupDATAI[DWIDTH-1:0]};
    assign pop      = txVALID & txREADY;
    assign pushOk   = loWr & (~txFULL | pop);
    assign dropped  = loWr & txFULL & ~pop;

    always_comb begin
        rdPtrNext = pop ? rdPtr + PW'(1) : rdPtr;
        levelNext = txLEVEL;
        case ({pushOk, pop})
            2'b10:   levelNext = txLEVEL + LW'(1);
            2'b01:   levelNext = txLEVEL - LW'(1);
            default: levelNext = txLEVEL;
        endcase
        // The new head comes from the push itself when it lands in the slot the
        // read pointer is about to point at (push into empty, or drain-to-one).
        headNext = (pushOk && (rdPtrNext == wrPtr)) ? pushData : mem[rdPtrNext];
    end

    always_ff @(posedge clk) begin
        if (pushOk && !clear) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            txLEVEL <= '0;
            txVALID <= 1'b0;
            txEMPTY <= 1'b1;
            txFULL  <= 1'b0;
            txDAT   <= '0;
            txSOM   <= 1'b0;
            txEOM   <= 1'b0;
            txABRT  <= 1'b0;
            staged  <= '0;
            datLast <= '0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + PW'(1);
            end
            rdPtr   <= rdPtrNext;
            txLEVEL <= levelNext;
            txVALID <= (levelNext != '0);
            txEMPTY <= (levelNext == '0);
            txFULL  <= (levelNext == LW'(DEPTH));
            if (levelNext != '0) begin
                {txABRT, txEOM, txSOM, txDAT} <= headNext;
            end else begin
                {txABRT, txEOM, txSOM, txDAT} <= '0;
            end
            // SOM/EOM are one-shot per accepted character; ABRT stays until software rewrites it.
            if (pushOk) begin
                staged <= {primed[2], 2'b00};
            end else begin
                staged <= primed;
            end
            if (loWr) begin
                datLast <= dupDATAI[DWIDTH-1:0];
            end
        end
    end

    assign regTXDBUF = {1'b0, dupRXCRC, 1'b0, dupTXCRC, dupMNTT, staged, 8'(datLast)};

`ifdef DUPTXFIFO_OVF_EN
    always_ff @(posedge clk) begin
        if (clear) begin
            txOVF <= 1'b0;
        end else if (dropped) begin
            txOVF <= 1'b1;
        end else if (ovfCLR) begin
            txOVF <= 1'b0;
        end
    end
`else
    assign txOVF = 1'b0;
`endif

    logic unusedBits;
    assign unusedBits = ^{dupDATAI, ovfCLR, dropped};

endmodule

// File: tb/tb_dup_txfifo.sv
// tb/tb_dup_txfifo.sv - directed self-checking bench for dup_txfifo
module tb_dup_txfifo;

    logic        clk = 1'b0;
    logic        rst, dupINIT, devLOBYTE, devHIBYTE, txdbufWRITE;
    logic [35:0] dupDATAI;
    logic        dupRXCRC, dupTXCRC, dupMNTT;
    logic [15:0] regTXDBUF;
    logic        txVALID, txREADY;
    logic [7:0]  txDAT;
    logic        txSOM, txEOM, txABRT, txEMPTY, txFULL;
    logic [2:0]  txLEVEL;
    logic        txOVF, ovfCLR;

    int nAsserts = 0;
    int nFails   = 0;

`ifdef DUPTXFIFO_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    dup_txfifo #(.DEPTH(4), .DWIDTH(8)) dut (
        .clk(clk), .rst(rst), .dupINIT(dupINIT),
        .devLOBYTE(devLOBYTE), .devHIBYTE(devHIBYTE), .txdbufWRITE(txdbufWRITE),
        .dupDATAI(dupDATAI), .dupRXCRC(dupRXCRC), .dupTXCRC(dupTXCRC), .dupMNTT(dupMNTT),
        .regTXDBUF(regTXDBUF), .txVALID(txVALID), .txREADY(txREADY),
        .txDAT(txDAT), .txSOM(txSOM), .txEOM(txEOM), .txABRT(txABRT),
        .txEMPTY(txEMPTY), .txFULL(txFULL), .txLEVEL(txLEVEL),
        .txOVF(txOVF), .ovfCLR(ovfCLR)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic hi, input logic lo, input logic [15:0] d);
        txdbufWRITE = 1'b1;
        devHIBYTE   = hi;
        devLOBYTE   = lo;
        dupDATAI    = {20'h0, d};
        tick();
        txdbufWRITE = 1'b0;
        devHIBYTE   = 1'b0;
        devLOBYTE   = 1'b0;
        dupDATAI    = '0;
    endtask

    initial begin
        rst = 1'b1; dupINIT = 1'b0; devLOBYTE = 1'b0; devHIBYTE = 1'b0;
        txdbufWRITE = 1'b0; dupDATAI = '0; dupRXCRC = 1'b0; dupTXCRC = 1'b0;
        dupMNTT = 1'b0; txREADY = 1'b0; ovfCLR = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // reset state
        chk("rst_empty", 32'(txEMPTY), 32'd1);
        chk("rst_valid", 32'(txVALID), 32'd0);
        chk("rst_level", 32'(txLEVEL), 32'd0);
        chk("rst_full",  32'(txFULL),  32'd0);
        chk("rst_reg",   32'(regTXDBUF), 32'h0000);
        chk("rst_ovf",   32'(txOVF),   32'd0);

        // word writes SOM+'A', EOM+'B', then drain
        wr(1'b1, 1'b1, 16'h0141);
        chk("w1_level", 32'(txLEVEL), 32'd1);
        chk("w1_head",  32'({txSOM, txEOM, txDAT}), 32'h241);
        chk("w1_reg",   32'(regTXDBUF), 32'h0041);
        wr(1'b1, 1'b1, 16'h0242);
        chk("w2_level", 32'(txLEVEL), 32'd2);
        chk("w2_head",  32'(txDAT), 32'h41);
        txREADY = 1'b1;
        tick();
        chk("p1_head",  32'({txSOM, txEOM, txDAT}), 32'h142);
        chk("p1_level", 32'(txLEVEL), 32'd1);
        tick();
        chk("p2_empty", 32'(txEMPTY), 32'd1);
        chk("p2_valid", 32'(txVALID), 32'd0);
        chk("p2_dat",   32'(txDAT), 32'h00);
        txREADY = 1'b0;

        // HIBYTE-only stages SOM, next LOBYTE consumes it
        wr(1'b1, 1'b0, 16'h0100);
        chk("hi_level", 32'(txLEVEL), 32'd0);
        chk("hi_reg",   32'(regTXDBUF), 32'h0142);
        wr(1'b0, 1'b1, 16'h0055);
        chk("lo1_head", 32'({txSOM, txDAT}), 32'h155);
        chk("lo1_reg",  32'(regTXDBUF), 32'h0055);
        wr(1'b0, 1'b1, 16'h0066);
        txREADY = 1'b1;
        tick();
        chk("lo2_head", 32'({txSOM, txDAT}), 32'h066);
        tick();
        chk("lo2_empty", 32'(txEMPTY), 32'd1);
        txREADY = 1'b0;

        // fill to full, fifth push (with staged SOM) dropped
        for (int i = 0; i < 4; i++) wr(1'b0, 1'b1, 16'h0010 + 16'(i));
        chk("full_level", 32'(txLEVEL), 32'd4);
        chk("full_flag",  32'(txFULL),  32'd1);
        wr(1'b1, 1'b1, 16'h0114);
        chk("drop_level", 32'(txLEVEL), 32'd4);
        chk("drop_head",  32'(txDAT),   32'h10);
        chk("drop_ovf",   32'(txOVF),   32'(OVF_EXP));
        chk("drop_reg",   32'(regTXDBUF), 32'h0114);
        ovfCLR = 1'b1;
        tick();
        ovfCLR = 1'b0;
        chk("ovfclr", 32'(txOVF), 32'd0);

        // full: push+pop in the same cycle keeps level and order
        txREADY = 1'b1;
        wr(1'b0, 1'b1, 16'h0020);
        chk("pp_level", 32'(txLEVEL), 32'd4);
        chk("pp_head",  32'(txDAT),   32'h11);
        tick();
        chk("pp_h12", 32'(txDAT), 32'h12);
        tick();
        chk("pp_h13", 32'(txDAT), 32'h13);
        tick();
        chk("pp_h20", 32'({txSOM, txDAT}), 32'h120);
        tick();
        chk("pp_empty", 32'(txEMPTY), 32'd1);
        txREADY = 1'b0;

        // dupINIT during pop with 3 entries and a pending write
        for (int i = 0; i < 3; i++) wr(1'b0, 1'b1, 16'h0031 + 16'(i));
        wr(1'b1, 1'b0, 16'h0400);
        chk("init_pre_level", 32'(txLEVEL), 32'd3);
        chk("init_pre_reg",   32'(regTXDBUF), 32'h0433);
        txREADY = 1'b1;
        dupINIT = 1'b1;
        wr(1'b1, 1'b1, 16'h0377);
        dupINIT = 1'b0;
        txREADY = 1'b0;
        chk("init_level", 32'(txLEVEL), 32'd0);
        chk("init_valid", 32'(txVALID), 32'd0);
        chk("init_flags", 32'({txABRT, txEOM, txSOM, txDAT}), 32'h000);
        chk("init_reg",   32'(regTXDBUF), 32'h0000);

        // readback-only status bits
        dupRXCRC = 1'b1; dupTXCRC = 1'b1; dupMNTT = 1'b1;
        #1;
        chk("crc_reg", 32'(regTXDBUF), 32'h5800);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
